prm_edge_sched: RTL and testbench

PRM_EDGE_SCHED -- requirements
Module: prm_edge_sched

---
 rtl/prm_edge_sched.sv | 173 +++++++++++++++++
 tb/tb_prm_edge_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_sched.sv
// prm_edge_sched
//   Walks a batch of roadmap edges stored in an external edge ROM. Each
//   edge code is fetched, registered onto chk_vec for an external
//   combinational obstacle checker, and the checker verdict is reported
//   through a valid/ready result port. Blocked edges are counted per batch.
//   Each edge takes 4 cycles (FETCH, LOAD, CHECK, EMIT) when res_ready is
//   held high.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle batch request, sampled only in IDLE
//   abort        terminate the current batch (priority over start)
//   base_addr    first edge ROM address of the batch
//   edge_cnt     number of edges in the batch, 0..2^AW
//   busy         high in every state except IDLE
//   done         one-cycle pulse at batch completion
//   rom_rd       edge ROM read strobe
//   rom_addr     edge ROM address
//   rom_data     edge code, valid the cycle after rom_rd
//   chk_vec      registered edge code driving the obstacle checker
//   chk_mask     checker verdict, 1 = edge blocked
//   res_valid    result valid
//   res_ready    result ready
//   res_idx      ROM address of the reported edge
//   res_mask     blocked flag of the reported edge
//   blocked_cnt  blocked edges in the current or last batch
module prm_edge_sched #(
    parameter int AW = 6,
    parameter int VW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   edge_cnt,
    output logic          busy,
    output logic          done,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [VW-1:0] rom_data,
    output logic [VW-1:0] chk_vec,
    input  logic          chk_mask,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [AW-1:0] res_idx,
    output logic          res_mask,
    output logic [AW:0]   blocked_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        CHECK = 3'd3,
        EMIT  = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   rem_cnt;

    // Control strobes decoded by the next-state logic
    logic batch_go;   // latch base_addr / edge_cnt
    logic cnt_clr;    // clear blocked_cnt at batch start
    logic vec_ld;     // capture rom_data into chk_vec
    logic res_ld;     // capture checker verdict into result registers
    logic adv;        // result handshake: step address, consume one edge

    // Saturating increment; with edge_cnt <= 2^AW the ceiling is never
    // reached in normal use, it only guards against wrap.
    function automatic logic [AW:0] sat_inc(input logic [AW:0] cnt,
                                            input logic        inc);
        if (inc && (cnt != {(AW+1){1'b1}}))
            return cnt + (AW+1)'(1);
        return cnt;
    endfunction

    assign rom_addr = cur_addr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FIN);
        rom_rd    = (state == FETCH);
        res_valid = (state == EMIT);
        batch_go  = 1'b0;
        cnt_clr   = 1'b0;
        vec_ld    = 1'b0;
        res_ld    = 1'b0;
        adv       = 1'b0;

        // abort wins everywhere; in IDLE it also suppresses a coincident start
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt_clr = 1'b1;
                        if (edge_cnt != '0) begin
                            batch_go  = 1'b1;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = FIN;
                        end
                    end
                end
                FETCH: state_nxt = LOAD;
                LOAD: begin
                    vec_ld    = 1'b1;
                    state_nxt = CHECK;
                end
                CHECK: begin
                    res_ld    = 1'b1;
                    state_nxt = EMIT;
                end
                EMIT: begin
                    if (res_ready) begin
                        adv       = 1'b1;
                        state_nxt = (rem_cnt == (AW+1)'(1)) ? FIN : FETCH;
                    end
                end
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            rem_cnt     <= '0;
            chk_vec     <= '0;
            res_idx     <= '0;
            res_mask    <= 1'b0;
            blocked_cnt <= '0;
        end else begin
            if (batch_go) begin
                cur_addr <= base_addr;
                rem_cnt  <= edge_cnt;
            end
            if (cnt_clr)
                blocked_cnt <= '0;
            if (vec_ld)
                chk_vec <= rom_data;
            if (res_ld) begin
                res_idx     <= cur_addr;
                res_mask    <= chk_mask;
                blocked_cnt <= sat_inc(blocked_cnt, chk_mask);
            end
            // Address wraps naturally modulo 2^AW
            if (adv) begin
                cur_addr <= cur_addr + AW'(1);
                rem_cnt  <= rem_cnt - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_sched.sv
// Directed bench for prm_edge_sched with an edge ROM model, a combinational
// checker model and a result scoreboard.
module tb_prm_edge_sched;

    localparam int AW = 6;
    localparam int VW = 15;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   edge_cnt;
    logic          busy;
    logic          done;
    logic          rom_rd;
    logic [AW-1:0] rom_addr;
    logic [VW-1:0] rom_data;
    logic [VW-1:0] chk_vec;
    logic          chk_mask;
    logic          res_valid;
    logic          res_ready;
    logic [AW-1:0] res_idx;
    logic          res_mask;
    logic [AW:0]   blocked_cnt;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [AW-1:0] idx;
        logic          mask;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [AW-1:0] rd_log[$];
    logic [VW-1:0] rom[64];

    prm_edge_sched #(.AW(AW), .VW(VW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .base_addr   (base_addr),
        .edge_cnt    (edge_cnt),
        .busy        (busy),
        .done        (done),
        .rom_rd      (rom_rd),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .chk_vec     (chk_vec),
        .chk_mask    (chk_mask),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_idx     (res_idx),
        .res_mask    (res_mask),
        .blocked_cnt (blocked_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Obstacle checker model: (A & D) | (O & ~B) | (H ^ J)
    function automatic logic chkf(input logic [VW-1:0] v);
        return (v[0] & v[3]) | (v[14] & ~v[1]) | (v[7] ^ v[9]);
    endfunction

    assign chk_mask = chkf(chk_vec);

    // Edge ROM: synchronous read, data the cycle after rom_rd
    always @(posedge clk) begin
        if (rom_rd)
            rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: log ROM reads and score results on handshake
    always @(negedge clk) begin
        if (rom_rd)
            rd_log.push_back(rom_addr);
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                assert (sb.size() != 0)
                else begin
                    n_fail++;
                    $error("FAIL sb_unexpected observed idx=%0h expected=none", res_idx);
                end
            end else begin
                mon_e = sb.pop_front();
                chk("res_idx", 32'(res_idx), 32'(mon_e.idx));
                chk("res_mask", 32'(res_mask), 32'(mon_e.mask));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},      32'(busy),        0);
        chk({tag, "_done"},      32'(done),        0);
        chk({tag, "_rom_rd"},    32'(rom_rd),      0);
        chk({tag, "_res_valid"}, 32'(res_valid),   0);
        chk({tag, "_res_mask"},  32'(res_mask),    0);
        chk({tag, "_rom_addr"},  32'(rom_addr),    0);
        chk({tag, "_res_idx"},   32'(res_idx),     0);
        chk({tag, "_chk_vec"},   32'(chk_vec),     0);
        chk({tag, "_blk_cnt"},   32'(blocked_cnt), 0);
    endtask

    // Pushes expected results, returns expected blocked count
    task automatic push_exp(input logic [AW-1:0] base, input int cnt, output int blk);
        logic [AW-1:0] a;
        blk = 0;
        for (int i = 0; i < cnt; i++) begin
            a = base + AW'(i);
            sb.push_back('{a, chkf(rom[a])});
            blk += int'(chkf(rom[a]));
        end
    endtask

    task automatic run_batch(input logic [AW-1:0] base, input int cnt, input string tag);
        int edges;
        int exp_blk;
        logic [AW-1:0] a;
        rd_log.delete();
        push_exp(base, cnt, exp_blk);
        base_addr = base;
        edge_cnt  = (AW+1)'(cnt);
        start     = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 1000) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 32'(edges), 32'(4 * cnt + 1));
        chk({tag, "_blk_cnt"}, 32'(blocked_cnt), 32'(exp_blk));
        chk({tag, "_rd_count"}, 32'(rd_log.size()), 32'(cnt));
        for (int i = 0; i < rd_log.size() && i < cnt; i++) begin
            a = base + AW'(i);
            chk({tag, "_rd_addr"}, 32'(rd_log[i]), 32'(a));
        end
        tick();
        chk({tag, "_done_1cyc"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int edges;
        int exp_blk;
        int blk_kept;
        logic exp_m;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        edge_cnt  = '0;
        res_ready = 1'b1;
        rom_data  = '0;
        for (int i = 0; i < 64; i++)
            rom[i] = VW'((i * 32'h1357) ^ 32'h2AA5);
        rom[5] = 15'h4C8A;
        rom[6] = 15'h0001;
        rom[7] = 15'h7FFF;

        // Reset state
        tick();
        tick();
        chk_zero("reset");

        // First start right after release; base 5, 3 edges
        rst_n = 1'b1;
        run_batch(6'd5, 3, "b5x3");

        // Empty batch clears a nonzero blocked count
        run_batch(6'd9, 0, "empty");

        // Address wrap 62, 63, 0, 1
        run_batch(6'd62, 4, "wrap");

        // Back-pressure in EMIT
        rd_log.delete();
        push_exp(6'd10, 2, exp_blk);
        res_ready = 1'b0;
        base_addr = 6'd10;
        edge_cnt  = 7'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        while (!res_valid && edges < 50) begin
            tick();
            edges++;
        end
        chk("stall_first_valid", 32'(edges), 4);
        exp_m = chkf(rom[10]);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(res_valid), 1);
            chk("stall_idx", 32'(res_idx), 10);
            chk("stall_mask", 32'(res_mask), 32'(exp_m));
        end
        chk("stall_no_rd", 32'(rd_log.size()), 1);
        res_ready = 1'b1;
        edges = 0;
        while (!done && edges < 50) begin
            tick();
            edges++;
        end
        chk("stall_done", 32'(done), 1);
        chk("stall_blk_cnt", 32'(blocked_cnt), 32'(exp_blk));
        tick();
        chk("stall_sb_empty", 32'(sb.size()), 0);

        // Abort in CHECK of edge 2 of 4
        rd_log.delete();
        push_exp(6'd20, 1, exp_blk);
        base_addr = 6'd20;
        edge_cnt  = 7'd4;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++)
            tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_blk_cnt", 32'(blocked_cnt), 32'(exp_blk));
        chk("abort_rd_count", 32'(rd_log.size()), 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
        end
        chk("abort_sb_empty", 32'(sb.size()), 0);

        // abort with start in IDLE: no batch, count kept
        blk_kept  = exp_blk;
        base_addr = 6'd33;
        edge_cnt  = 7'd2;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_blk", 32'(blocked_cnt), 32'(blk_kept));
        tick();
        chk("abort_start_busy2", 32'(busy), 0);

        run_batch(6'd40, 1, "post_abort");

        // Ignored start while busy, then reset mid-EMIT
        rd_log.delete();
        push_exp(6'd30, 3, exp_blk);
        res_ready = 1'b0;
        base_addr = 6'd30;
        edge_cnt  = 7'd3;
        start     = 1'b1;
        tick();
        base_addr = 6'd50;
        edge_cnt  = 7'd1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("busy_start_valid", 32'(res_valid), 1);
        chk("busy_start_idx", 32'(res_idx), 30);
        chk("busy_start_rd", 32'(rd_log.size()), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        sb.delete();
        tick();
        chk("midrst_done", 32'(done), 0);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        tick();
        chk("midrst_idle_done", 32'(done), 0);

        run_batch(6'd0, 2, "post_rst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
